// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared op codes, FSM state encoding and default width
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// muldiv_iter : one-bit-per-cycle unsigned shift-add multiply / restoring divide
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module muldiv_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               isDiv_i,
  input  logic [WIDTH-1:0]   magA_i,
  input  logic [WIDTH-1:0]   magB_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   shf_q, shf_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     trial;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    shf_d    = shf_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    isDiv_d  = isDiv_q;
    remShift = {rem_q, shf_q[WIDTH-1]};
    // Borrow out of the trial subtraction means the divisor does not fit
    trial    = remShift - {1'b0, mcand_q[WIDTH-1:0]};
    if (load_i) begin
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, (isDiv_i ? magB_i : magA_i)};
      shf_d   = isDiv_i ? magA_i : magB_i;
      rem_d   = '0;
      cnt_d   = '0;
      isDiv_d = isDiv_i;
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (isDiv_q) begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          shf_d = {shf_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = remShift[WIDTH-1:0];
          shf_d = {shf_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (shf_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
        shf_d   = {1'b0, shf_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      shf_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      isDiv_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shf_q   <= shf_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      isDiv_q <= isDiv_d;
    end
  end

  assign product_o  = acc_q;
  assign quotient_o = shf_q;
  assign last_o     = (cnt_q == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// alu_sequencer : multi-cycle signed add/sub/mul/div with memory-recall register
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             memStore,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             divZero,
  output logic [WIDTH-1:0] memValue
);

  localparam logic [2*WIDTH-1:0] MAXPOS = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MINMAG = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q, mem_q;
  logic               neg_q, ovf_q, dz_q;
  logic               coreLoad, coreStep, coreLast;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, magA, magB, mulLow, mulRes, divRes;
  logic [WIDTH:0]     sumExt;
  logic               sumOvf, mulOvf, divOvf, bZero, isIter;

  assign magA   = a_q[WIDTH-1] ? -a_q : a_q;
  assign magB   = b_q[WIDTH-1] ? -b_q : b_q;
  assign bZero  = (b_q == '0);
  assign isIter = (op_q == OP_MUL) || ((op_q == OP_DIV) && !bZero);
  assign sumExt = (op_q == OP_SUB) ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                                   : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});
  assign sumOvf = sumExt[WIDTH] ^ sumExt[WIDTH-1];
  // A negative result may reach one further magnitude than a positive one
  assign mulLow = product[WIDTH-1:0];
  assign mulRes = neg_q ? -mulLow : mulLow;
  assign mulOvf = neg_q ? (product > MINMAG) : (product > MAXPOS);
  assign divRes = neg_q ? -quotient : quotient;
  assign divOvf = !neg_q && quotient[WIDTH-1];

  muldiv_iter #(.WIDTH(WIDTH)) u_core (
    .Clock      (Clock),
    .reset      (reset),
    .load_i     (coreLoad),
    .step_i     (coreStep),
    .isDiv_i    (op_q == OP_DIV),
    .magA_i     (magA),
    .magB_i     (magB),
    .product_o  (product),
    .quotient_o (quotient),
    .last_o     (coreLast)
  );

  always_ff @(posedge Clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = isIter ? ST_EXEC : ST_DONE;
      ST_EXEC: if (coreLast) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    coreLoad = (state_q == ST_LOAD);
    coreStep = (state_q == ST_EXEC);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      mem_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The store sees the pre-start result even when start is also high
          if (memStore && !ovf_q && !dz_q) mem_q <= result_q;
          if (start) begin
            op_q <= op_t'(op);
            a_q  <= operandA;
            b_q  <= operandB;
          end
        end
        ST_LOAD: begin
          neg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            result_q <= sumExt[WIDTH-1:0];
            ovf_q    <= sumOvf;
            dz_q     <= 1'b0;
          end else if ((op_q == OP_DIV) && bZero) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b1;
          end
        end
        ST_FIX: begin
          result_q <= (op_q == OP_DIV) ? divRes : mulRes;
          ovf_q    <= (op_q == OP_DIV) ? divOvf : mulOvf;
          dz_q     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;
  assign divZero  = dz_q;
  assign memValue = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// tb_alu_sequencer : directed and random checks of alu_sequencer against a model
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         reset, start, memStore;
  logic [1:0]   op;
  logic [W-1:0] operandA, operandB;
  logic         busy, done, overflow, divZero;
  logic [W-1:0] result, memValue;

  int n_assert = 0;
  int n_fail   = 0;

  alu_sequencer #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operandA (operandA),
    .operandB (operandB),
    .memStore (memStore),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .divZero  (divZero),
    .memValue (memValue)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int res;
    int ovf;
    int dz;
    int lat;
  } exp_t;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then range check and wrap to W bits
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint t;
    longint lo_lim = -(longint'(1) << (W - 1));
    longint hi_lim = (longint'(1) << (W - 1)) - 1;
    logic signed [W-1:0] low;
    exp_t e;
    e.dz  = 0;
    e.lat = 2;
    t     = 0;
    case (o)
      2'd0: t = sa + sb;
      2'd1: t = sa - sb;
      2'd2: begin t = sa * sb; e.lat = W + 3; end
      default: begin
        if (sb == 0) e.dz = 1;
        else begin t = sa / sb; e.lat = W + 3; end
      end
    endcase
    e.ovf = (t < lo_lim || t > hi_lim) ? 1 : 0;
    low   = t[W-1:0];
    e.res = low;
    return e;
  endfunction

  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ms);
    exp_t e;
    int   lat;
    e = model(o, a, b);
    @(negedge Clock);
    start = 1'b1; op = o; operandA = a; operandB = b; memStore = ms;
    @(posedge Clock); #1;
    start = 1'b0; memStore = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      chk({tag, " busy"}, busy, 1);
      @(posedge Clock); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " result"}, $signed(result), e.res);
    chk({tag, " overflow"}, overflow, e.ovf);
    chk({tag, " divZero"}, divZero, e.dz);
    @(posedge Clock); #1;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  task automatic mem_store(input string tag, input int exp);
    @(negedge Clock);
    memStore = 1'b1;
    @(posedge Clock); #1;
    memStore = 1'b0;
    chk(tag, $signed(memValue), exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; memStore = 1'b0; op = 2'd0;
    operandA = '0; operandB = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset overflow", overflow, 0);
    chk("reset divZero", divZero, 0);
    chk("reset memValue", memValue, 0);
    @(negedge Clock);
    reset = 1'b0;

    do_op("add 100+-30", 2'd0, 16'd100, -16'sd30, 1'b0);
    chk("add 100+-30 value", $signed(result), 70);
    do_op("add max+1", 2'd0, 16'h7FFF, 16'd1, 1'b0);
    do_op("sub min-1", 2'd1, 16'h8000, 16'd1, 1'b0);
    do_op("mul -123x45", 2'd2, -16'sd123, 16'd45, 1'b0);
    chk("mul -123x45 value", $signed(result), -5535);
    do_op("mul 300x200", 2'd2, 16'd300, 16'd200, 1'b0);
    chk("mul 300x200 value", $signed(result), -5536);
    do_op("div -7/2", 2'd3, -16'sd7, 16'd2, 1'b0);
    chk("div -7/2 value", $signed(result), -3);
    do_op("div 5/0", 2'd3, 16'd5, 16'd0, 1'b0);
    do_op("div min/-1", 2'd3, 16'h8000, 16'hFFFF, 1'b0);
    chk("div min/-1 ovf", overflow, 1);

    do_op("mul 12x3", 2'd2, 16'd12, 16'd3, 1'b0);
    mem_store("mem after 36", 36);
    do_op("div 5/0 b", 2'd3, 16'd5, 16'd0, 1'b0);
    mem_store("mem after divzero", 36);
    do_op("add 5+5", 2'd0, 16'd5, 16'd5, 1'b0);
    do_op("add 1+1 with store", 2'd0, 16'd1, 16'd1, 1'b1);
    chk("mem pre-start result", $signed(memValue), 10);
    mem_store("mem after 2", 2);

    // Reset in the middle of a multiply
    @(negedge Clock);
    start = 1'b1; op = 2'd2; operandA = -16'sd123; operandB = 16'd45;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (6) @(posedge Clock);
    #1;
    chk("exec5 busy", busy, 1);
    @(negedge Clock);
    reset = 1'b1;
    @(posedge Clock); #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort overflow", overflow, 0);
    chk("abort divZero", divZero, 0);
    chk("abort memValue", memValue, 0);
    @(negedge Clock);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge Clock); #1;
      if (done === 1'b1) seen++;
    end
    chk("abort no done", seen, 0);

    // A start while busy must not produce a second operation
    @(negedge Clock);
    start = 1'b1; op = 2'd2; operandA = 16'd7; operandB = 16'd9;
    @(posedge Clock); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 45; c++) begin
      if (c == 5) begin start = 1'b1; op = 2'd0; end
      if (c == 6) start = 1'b0;
      @(posedge Clock); #1;
      if (done === 1'b1) begin
        seen++;
        chk("busy-start result", $signed(result), 63);
      end
    end
    chk("busy-start done count", seen, 1);

    // A start during the done cycle is ignored
    @(negedge Clock);
    start = 1'b1; op = 2'd0; operandA = 16'd3; operandB = 16'd4;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    chk("coincide done", done, 1);
    start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    chk("coincide idle", busy, 0);
    seen = 0;
    repeat (10) begin
      @(posedge Clock); #1;
      if (busy === 1'b1 || done === 1'b1) seen++;
    end
    chk("coincide ignored", seen, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      int           sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rb  = W'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      if (sel == 1) ra = 16'h8000;
      if (sel == 2) rb = 16'hFFFF;
      do_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
